// File: rtl/serial_frame_receiver.sv
// serial_frame_receiver
// Hunts for a start bit on a serial line, shifts in N data bits LSB-first,
// checks an optional even-parity bit and the stop bit, and presents the
// assembled word on a one-entry valid/ready output buffer with overrun
// detection. All outputs are registered.

module serial_frame_receiver #(
  parameter int N         = 8,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_si,
  input  logic         i_bit_en,
  input  logic         i_ready,
  output logic [N-1:0] o_dout,
  output logic         o_valid,
  output logic         o_par_err,
  output logic         o_frm_err,
  output logic         o_overrun,
  output logic         o_busy
);

  localparam int CNT_W = $clog2(N + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [N-1:0]     r_sr;
  logic [CNT_W-1:0] r_cnt;
  logic             r_perr;

  logic [N-1:0]     r_dout;
  logic             r_valid;
  logic             r_par_err;
  logic             r_frm_err;
  logic             r_overrun;
  logic             r_busy;

  logic             w_last_data;
  logic             w_stop_edge;
  logic             w_load;

  // A correct even-parity bit equals the XOR of the data bits, so any
  // difference between the two flags a parity error.
  function automatic logic f_par_mismatch(input logic par_bit,
                                          input logic [N-1:0] data);
    return par_bit ^ (^data);
  endfunction

  assign w_last_data = (r_cnt == CNT_W'(N - 1));
  assign w_stop_edge = i_bit_en && (r_state == S_STOP);
  // A new frame may land only if the buffer is empty or drained this edge.
  assign w_load      = w_stop_edge && (!r_valid || i_ready);

  // Next-state logic: only bit_en edges move the receiver along.
  always_comb begin
    w_state_nxt = r_state;
    if (i_bit_en) begin
      case (r_state)
        S_IDLE:   if (!i_si) w_state_nxt = S_DATA;
        S_DATA:   if (w_last_data) w_state_nxt = PARITY_EN ? S_PARITY : S_STOP;
        S_PARITY: w_state_nxt = S_STOP;
        S_STOP:   w_state_nxt = S_IDLE;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Frame assembly: shift register, bit counter and captured parity result.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sr   <= '0;
      r_cnt  <= '0;
      r_perr <= 1'b0;
    end else if (i_bit_en) begin
      case (r_state)
        S_IDLE: begin
          if (!i_si) begin
            r_cnt  <= '0;
            r_perr <= 1'b0;
          end
        end
        S_DATA: begin
          r_sr  <= {i_si, r_sr[N-1:1]};
          r_cnt <= r_cnt + CNT_W'(1);
        end
        S_PARITY: r_perr <= f_par_mismatch(i_si, r_sr);
        default: ;
      endcase
    end
  end

  // Output buffer: commit on the stop-bit edge, drop with overrun if full.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dout    <= '0;
      r_valid   <= 1'b0;
      r_par_err <= 1'b0;
      r_frm_err <= 1'b0;
      r_overrun <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      r_busy    <= (w_state_nxt != S_IDLE);
      if (w_load) begin
        r_dout    <= r_sr;
        r_par_err <= PARITY_EN ? r_perr : 1'b0;
        r_frm_err <= ~i_si;
        r_valid   <= 1'b1;
      end else if (w_stop_edge) begin
        r_overrun <= 1'b1;
      end else if (r_valid && i_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_dout    = r_dout;
  assign o_valid   = r_valid;
  assign o_par_err = r_par_err;
  assign o_frm_err = r_frm_err;
  assign o_overrun = r_overrun;
  assign o_busy    = r_busy;

endmodule
